// File: rtl/pmp_pkg.sv
// Shared types for the PMP unit: A-field encoding, cfg bit layout,
// decoded region record and decoder state.
package pmp_pkg;

   // Region addresses are word addresses of a 56-bit physical space.
   localparam int PMP_AW  = 54;
   localparam int PMP_MAX = 16;

   typedef enum logic [1:0] {
      PMP_OFF   = 2'd0,
      PMP_TOR   = 2'd1,
      PMP_NA4   = 2'd2,
      PMP_NAPOT = 2'd3
   } pmp_a_e;

   // pmpcfg byte layout: L,-,-,A[1:0],X,W,R
   localparam int CFG_R    = 0;
   localparam int CFG_W    = 1;
   localparam int CFG_X    = 2;
   localparam int CFG_A_LO = 3;
   localparam int CFG_L    = 7;

   typedef struct packed {
      logic              valid;
      logic              locked;
      logic [2:0]        prot;
      logic [PMP_AW-1:0] start;
      logic [PMP_AW-1:0] aend;
   } pmp_region_t;

   typedef enum logic [1:0] {
      DEC_IDLE = 2'd0,
      DEC_DEC0 = 2'd1,
      DEC_DEC1 = 2'd2
   } dec_state_e;

   function automatic pmp_a_e cfg_mode(input logic [7:0] cfg);
      return pmp_a_e'(cfg[CFG_A_LO +: 2]);
   endfunction

endpackage

// File: rtl/pmp_region_cmp.sv
// Range/permission comparison of one access against one decoded region.
module pmp_region_cmp
   import pmp_pkg::*;
(
   input  pmp_region_t       region,
   input  logic [PMP_AW-1:0] addr,
   input  logic [1:0]        sz,
   input  logic [2:0]        xwr,
   input  logic              m,
   input  logic              su,
   input  logic              mprv,
   output logic              match,
   output logic              bad
);

   logic [PMP_AW-1:0] span;
   logic [PMP_AW-1:0] nd;
   logic              lo1, lo2, hi1, hi2;
   logic              enforce;

   // Last word touched: the access is naturally aligned, so OR-ing the size in is enough.
   assign span = (sz == 2'd0) ? '0 : (sz == 2'd1) ? PMP_AW'(1) : PMP_AW'(3);
   assign nd   = addr | span;

   assign lo1 = region.start <= addr;
   assign lo2 = region.start <= nd;
   assign hi1 = addr <= region.aend;
   assign hi2 = nd <= region.aend;

   // Any overlap counts as a match; partial overlap is then reported as bad.
   assign match   = region.valid && !((!lo1 && !lo2) || (!hi1 && !hi2));
   assign enforce = region.locked || su || (m && mprv);
   assign bad     = (!(lo1 && hi2) || ((region.prot & xwr) == 3'b000)) && enforce;

endmodule

// File: rtl/pmp_unit.sv
// PMP unit: pmpcfg/pmpaddr registers, sequential region decoder and a
// two-stage multi-port access checker.
module pmp_unit
   import pmp_pkg::*;
#(
   parameter int NPHYS   = 56,
   parameter int NUM_PMP = 16,
   parameter int NPORTS  = 2,
   parameter int TAGW    = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     csr_valid,
   output logic                     csr_ready,
   input  logic                     csr_cfg,
   input  logic [3:0]               csr_idx,
   input  logic [NPHYS-3:0]         csr_wdata,
   input  logic [3:0]               csr_rd_idx,
   output logic [7:0]               csr_rd_cfg,
   output logic [NPHYS-3:0]         csr_rd_addr,
   input  logic [NPORTS-1:0]        chk_valid,
   output logic                     chk_ready,
   input  logic [NPORTS*(NPHYS-2)-1:0] chk_addr,
   input  logic [NPORTS*2-1:0]      chk_sz,
   input  logic [NPORTS*3-1:0]      chk_xwr,
   input  logic [NPORTS-1:0]        chk_m,
   input  logic [NPORTS-1:0]        chk_su,
   input  logic [NPORTS-1:0]        chk_mprv,
   input  logic [NPORTS*TAGW-1:0]   chk_tag,
   output logic [NPORTS-1:0]        res_valid,
   output logic [NPORTS-1:0]        res_fail,
   output logic [NPORTS*TAGW-1:0]   res_tag
);

   localparam int AW = NPHYS - 2;

   if (AW != PMP_AW) begin : g_aw_check
      $error("pmp_unit: NPHYS must be %0d", PMP_AW + 2);
   end

   logic [7:0]    cfg_q    [PMP_MAX];
   logic [AW-1:0] addr_q   [PMP_MAX];
   pmp_region_t   region_q [PMP_MAX];

   dec_state_e state_q, state_d;
   logic [3:0] wr_idx_q;
   logic       idle_c;

   logic [3:0] idx_plus1;
   logic       idx_ok, next_tor_locked, wr_drop, wr_ok;
   logic       dec1_needed;
   logic [3:0] dec_idx;
   logic [AW-1:0] prev_addr;
   pmp_region_t   dec_region;

   function automatic pmp_region_t decode_entry(input logic [7:0]    cfg,
                                                input logic [AW-1:0] addr,
                                                input logic [AW-1:0] prev);
      pmp_region_t   r;
      logic [AW-1:0] mask;
      r      = '0;
      // addr ^ (addr+1) sets the trailing ones plus the next bit; all-ones gives the full space.
      mask     = addr ^ (addr + AW'(1));
      r.locked = cfg[CFG_L];
      r.prot   = cfg[CFG_X:CFG_R];
      case (cfg_mode(cfg))
         PMP_TOR: begin
            r.start = prev;
            r.aend  = addr - AW'(1);
            r.valid = addr > prev;
         end
         PMP_NA4: begin
            r.start = addr;
            r.aend  = addr;
            r.valid = 1'b1;
         end
         PMP_NAPOT: begin
            r.start = addr & ~mask;
            r.aend  = addr | mask;
            r.valid = 1'b1;
         end
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

   assign idx_plus1       = csr_idx + 4'd1;
   assign idx_ok          = {1'b0, csr_idx} < 5'(NUM_PMP);
   // A locked TOR entry also freezes the address register below it.
   assign next_tor_locked = (({1'b0, csr_idx} + 5'd1) < 5'(NUM_PMP)) &&
                            cfg_q[idx_plus1][CFG_L] && (cfg_mode(cfg_q[idx_plus1]) == PMP_TOR);
   assign wr_drop         = cfg_q[csr_idx][CFG_L] || (!csr_cfg && next_tor_locked);
   assign wr_ok           = csr_valid && csr_ready && idx_ok && !wr_drop;

   // CSR register file write
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PMP_MAX; i++) begin
            cfg_q[i]  <= 8'h00;
            addr_q[i] <= '0;
         end
      end else if (wr_ok) begin
         if (csr_cfg) cfg_q[csr_idx]  <= csr_wdata[7:0];
         else         addr_q[csr_idx] <= csr_wdata;
      end
   end

   assign csr_rd_cfg  = ({1'b0, csr_rd_idx} < 5'(NUM_PMP)) ? cfg_q[csr_rd_idx] : 8'h00;
   assign csr_rd_addr = ({1'b0, csr_rd_idx} < 5'(NUM_PMP)) ? addr_q[csr_rd_idx] : '0;

   assign dec1_needed = (({1'b0, wr_idx_q} + 5'd1) < 5'(NUM_PMP)) &&
                        (cfg_mode(cfg_q[wr_idx_q + 4'd1]) == PMP_TOR);

   // Decoder state register and captured write index
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= DEC_IDLE;
         wr_idx_q <= 4'd0;
      end else begin
         state_q <= state_d;
         if (wr_ok) wr_idx_q <= csr_idx;
      end
   end

   // Decoder next state; both handshakes are held off while a decode is pending
   always_comb begin
      state_d = state_q;
      idle_c  = 1'b0;
      case (state_q)
         DEC_IDLE: begin
            idle_c = 1'b1;
            if (wr_ok) state_d = DEC_DEC0;
         end
         DEC_DEC0: state_d = dec1_needed ? DEC_DEC1 : DEC_IDLE;
         DEC_DEC1: state_d = DEC_IDLE;
         default:  state_d = DEC_IDLE;
      endcase
   end

   assign csr_ready = idle_c;
   assign chk_ready = idle_c;

   assign dec_idx    = (state_q == DEC_DEC1) ? wr_idx_q + 4'd1 : wr_idx_q;
   assign prev_addr  = (dec_idx == 4'd0) ? '0 : addr_q[dec_idx - 4'd1];
   assign dec_region = decode_entry(cfg_q[dec_idx], addr_q[dec_idx], prev_addr);

   // Region table: one entry rewritten per decode cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PMP_MAX; i++) region_q[i] <= '0;
      end else if (state_q != DEC_IDLE) begin
         region_q[dec_idx] <= dec_region;
      end
   end

   logic                              any_valid;
   logic [NPORTS-1:0][NUM_PMP-1:0]    match_c, bad_c;
   logic [NPORTS-1:0]                 vld_p1;
   logic [NPORTS-1:0][NUM_PMP-1:0]    match_p1, bad_p1;
   logic [NPORTS-1:0][TAGW-1:0]       tag_p1;
   logic [NPORTS-1:0]                 dflt_p1;
   logic [NPORTS-1:0]                 fail_c;

   // Any enabled region makes an unmatched S/U access fail
   always_comb begin
      any_valid = 1'b0;
      for (int e = 0; e < NUM_PMP; e++) any_valid = any_valid | region_q[e].valid;
   end

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      for (genvar e = 0; e < NUM_PMP; e++) begin : g_ent
         logic m_w, b_w;
         pmp_region_cmp u_cmp (
            .region (region_q[e]),
            .addr   (chk_addr[p*AW +: AW]),
            .sz     (chk_sz[p*2 +: 2]),
            .xwr    (chk_xwr[p*3 +: 3]),
            .m      (chk_m[p]),
            .su     (chk_su[p]),
            .mprv   (chk_mprv[p]),
            .match  (m_w),
            .bad    (b_w)
         );
         assign match_c[p][e] = m_w;
         assign bad_c[p][e]   = b_w;
      end
   end

   // ---- stage 1: per-entry compare results ----
   // Stage 1 valid
   always_ff @(posedge clk) begin
      if (reset) vld_p1 <= '0;
      else       vld_p1 <= chk_valid & {NPORTS{chk_ready}};
   end

   // Stage 1 data
   always_ff @(posedge clk) begin
      match_p1 <= match_c;
      bad_p1   <= bad_c;
      tag_p1   <= chk_tag;
      dflt_p1  <= chk_su & {NPORTS{any_valid}};
   end

   // ---- stage 2: priority select ----
   // Lowest-indexed matching entry decides; descending scan lets it overwrite
   always_comb begin
      for (int p = 0; p < NPORTS; p++) begin
         fail_c[p] = dflt_p1[p];
         for (int e = NUM_PMP - 1; e >= 0; e--) begin
            if (match_p1[p][e]) fail_c[p] = bad_p1[p][e];
         end
      end
   end

   // Result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         res_valid <= '0;
         res_fail  <= '0;
         res_tag   <= '0;
      end else begin
         res_valid <= vld_p1;
         res_fail  <= fail_c;
         res_tag   <= tag_p1;
      end
   end

endmodule

// File: tb/tb_pmp_unit.sv
// Scoreboard bench for pmp_unit: stimulus pushes expectations, monitor pops on res_valid.
module tb_pmp_unit;

   localparam int AW = 54;
   localparam logic [2:0] LD = 3'b001;
   localparam logic [2:0] ST = 3'b010;
   localparam logic [2:0] FE = 3'b100;

   logic             clk = 1'b0;
   logic             reset;
   logic             csr_valid, csr_ready, csr_cfg;
   logic [3:0]       csr_idx, csr_rd_idx;
   logic [AW-1:0]    csr_wdata, csr_rd_addr;
   logic [7:0]       csr_rd_cfg;
   logic [1:0]       chk_valid;
   logic             chk_ready;
   logic [2*AW-1:0]  chk_addr;
   logic [3:0]       chk_sz;
   logic [5:0]       chk_xwr;
   logic [1:0]       chk_m, chk_su, chk_mprv;
   logic [11:0]      chk_tag;
   logic [1:0]       res_valid, res_fail;
   logic [11:0]      res_tag;

   pmp_unit dut (
      .clk(clk), .reset(reset),
      .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_cfg(csr_cfg),
      .csr_idx(csr_idx), .csr_wdata(csr_wdata),
      .csr_rd_idx(csr_rd_idx), .csr_rd_cfg(csr_rd_cfg), .csr_rd_addr(csr_rd_addr),
      .chk_valid(chk_valid), .chk_ready(chk_ready), .chk_addr(chk_addr),
      .chk_sz(chk_sz), .chk_xwr(chk_xwr), .chk_m(chk_m), .chk_su(chk_su),
      .chk_mprv(chk_mprv), .chk_tag(chk_tag),
      .res_valid(res_valid), .res_fail(res_fail), .res_tag(res_tag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] tag;
      logic       fail;
      int         cyc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic [5:0] tag_cnt = 6'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic mon_port(input int p);
      exp_t e;
      logic got;
      got = 1'b0;
      e   = '{tag: 6'd0, fail: 1'b0, cyc: 0};
      if (p == 0 && q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      if (p == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_result port %0d: got res_valid=1, expected none", p);
      end else begin
         check($sformatf("res_tag[%0d]", p), 64'(res_tag[p*6 +: 6]), 64'(e.tag));
         check($sformatf("res_fail[%0d] tag %0d", p, e.tag), 64'(res_fail[p]), 64'(e.fail));
         check($sformatf("latency[%0d] tag %0d", p, e.tag), 64'(cyc), 64'(e.cyc + 2));
      end
   endtask

   // Monitor: compare every presented result against the head of its port queue
   always @(negedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (res_valid[p] === 1'b1) mon_port(p);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (csr_ready !== 1'b1 && n < 20) begin tick(); n++; end
      check("csr_ready_wait", 64'(csr_ready), 64'd1);
   endtask

   task automatic csr_write_raw(input logic c, input logic [3:0] idx, input logic [AW-1:0] d);
      wait_idle();
      csr_valid = 1'b1;
      csr_cfg   = c;
      csr_idx   = idx;
      csr_wdata = d;
      tick();
      csr_valid = 1'b0;
   endtask

   task automatic csr_write(input logic c, input logic [3:0] idx, input logic [AW-1:0] d);
      csr_write_raw(c, idx, d);
      wait_idle();
   endtask

   task automatic set_port(input int p, input logic [AW-1:0] a, input logic [1:0] sz,
                           input logic [2:0] xwr, input logic m, input logic su,
                           input logic mprv, input logic ef);
      exp_t e;
      chk_valid[p]        = 1'b1;
      chk_addr[p*AW +: AW] = a;
      chk_sz[p*2 +: 2]    = sz;
      chk_xwr[p*3 +: 3]   = xwr;
      chk_m[p]            = m;
      chk_su[p]           = su;
      chk_mprv[p]         = mprv;
      chk_tag[p*6 +: 6]   = tag_cnt;
      e = '{tag: tag_cnt, fail: ef, cyc: cyc};
      if (p == 0) q0.push_back(e);
      else        q1.push_back(e);
      tag_cnt = tag_cnt + 6'd1;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() + q1.size()) > 0 && n < 20) begin tick(); n++; end
      check("drain_pending", 64'(q0.size() + q1.size()), 64'd0);
   endtask

   // Single request on one port, then wait for its result
   task automatic req(input int p, input logic [AW-1:0] a, input logic [1:0] sz,
                      input logic [2:0] xwr, input logic m, input logic su,
                      input logic mprv, input logic ef);
      set_port(p, a, sz, xwr, m, su, mprv, ef);
      tick();
      chk_valid = 2'b00;
      drain();
   endtask

   task automatic rd_check(input logic [3:0] idx, input logic [7:0] ecfg, input logic [AW-1:0] eaddr);
      csr_rd_idx = idx;
      #1;
      check($sformatf("csr_rd_cfg[%0d]", idx), 64'(csr_rd_cfg), 64'(ecfg));
      check($sformatf("csr_rd_addr[%0d]", idx), 64'(csr_rd_addr), 64'(eaddr));
   endtask

   initial begin
      int n_csr, n_chk, fl0, fl1;
      reset = 1'b1; csr_valid = 1'b0; csr_cfg = 1'b0; csr_idx = '0; csr_wdata = '0;
      csr_rd_idx = '0; chk_valid = '0; chk_addr = '0; chk_sz = '0; chk_xwr = '0;
      chk_m = '0; chk_su = '0; chk_mprv = '0; chk_tag = '0;
      tick(); tick();
      reset = 1'b0;

      // Reset state
      check("rst_csr_ready", 64'(csr_ready), 64'd1);
      check("rst_chk_ready", 64'(chk_ready), 64'd1);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res_fail", 64'(res_fail), 64'd0);
      check("rst_res_tag", 64'(res_tag), 64'd0);
      rd_check(4'd0, 8'h00, '0);

      // Empty table: nothing faults
      req(0, 54'h400, 2'd0, LD, 1'b0, 1'b1, 1'b0, 1'b0);
      req(1, 54'h400, 2'd0, LD, 1'b1, 1'b0, 1'b0, 1'b0);

      // NAPOT words 0..0x7FF, read-only
      csr_write(1'b0, 4'd0, 54'h3FF);
      csr_write(1'b1, 4'd0, 54'h19);
      rd_check(4'd0, 8'h19, 54'h3FF);
      req(0, 54'h200, 2'd0, ST, 1'b0, 1'b1, 1'b0, 1'b1);
      req(0, 54'h200, 2'd0, LD, 1'b0, 1'b1, 1'b0, 1'b0);
      req(1, 54'h800, 2'd0, LD, 1'b0, 1'b1, 1'b0, 1'b1);
      req(1, 54'h800, 2'd0, LD, 1'b1, 1'b0, 1'b0, 1'b0);
      req(0, 54'h200, 2'd0, ST, 1'b1, 1'b0, 1'b0, 1'b0);
      req(0, 54'h200, 2'd0, ST, 1'b1, 1'b0, 1'b1, 1'b1);

      // Entry0 becomes NAPOT 0x400..0x401 (R), entry1 TOR 0x400..0x801 (RW)
      csr_write(1'b0, 4'd0, 54'h400);
      csr_write(1'b0, 4'd1, 54'h802);
      csr_write(1'b1, 4'd1, 54'h0B);
      req(0, 54'h800, 2'd2, LD, 1'b0, 1'b1, 1'b0, 1'b1);
      req(0, 54'h7FC, 2'd2, LD, 1'b0, 1'b1, 1'b0, 1'b0);
      req(1, 54'h800, 2'd1, LD, 1'b0, 1'b1, 1'b0, 1'b0);
      req(1, 54'h400, 2'd0, ST, 1'b0, 1'b1, 1'b0, 1'b1);
      req(0, 54'h500, 2'd0, ST, 1'b0, 1'b1, 1'b0, 1'b0);

      // Decoder busy: address write under a TOR entry needs two decode cycles
      csr_write_raw(1'b0, 4'd0, 54'h400);
      n_csr = 0; n_chk = 0;
      for (int i = 0; i < 10; i++) begin
         if (csr_ready !== 1'b1) n_csr++;
         if (chk_ready !== 1'b1) n_chk++;
         if (csr_ready === 1'b1) break;
         tick();
      end
      check("busy_csr_ready_cycles", 64'(n_csr), 64'd2);
      check("busy_chk_ready_cycles", 64'(n_chk), 64'd2);

      // Lock entry1 as TOR, execute-only
      csr_write(1'b1, 4'd1, 54'h8C);
      csr_write_raw(1'b0, 4'd0, 54'h123);
      check("dropped_write_ready", 64'(csr_ready), 64'd1);
      csr_write_raw(1'b1, 4'd1, 54'h00);
      rd_check(4'd0, 8'h19, 54'h400);
      rd_check(4'd1, 8'h8C, 54'h802);
      req(0, 54'h500, 2'd0, LD, 1'b1, 1'b0, 1'b0, 1'b1);
      req(1, 54'h500, 2'd0, FE, 1'b1, 1'b0, 1'b0, 1'b0);
      req(0, 54'h900, 2'd0, LD, 1'b1, 1'b0, 1'b0, 1'b0);

      // Both ports every cycle, reset in the middle
      set_port(0, 54'h400, 2'd0, LD, 1'b0, 1'b1, 1'b0, 1'b0);
      set_port(1, 54'h400, 2'd0, LD, 1'b0, 1'b1, 1'b0, 1'b0); tick();
      set_port(0, 54'h400, 2'd0, ST, 1'b0, 1'b1, 1'b0, 1'b1);
      set_port(1, 54'h500, 2'd0, LD, 1'b0, 1'b1, 1'b0, 1'b1); tick();
      set_port(0, 54'h500, 2'd0, FE, 1'b1, 1'b0, 1'b0, 1'b0);
      set_port(1, 54'h500, 2'd0, FE, 1'b0, 1'b1, 1'b0, 1'b0); tick();
      set_port(0, 54'h900, 2'd0, LD, 1'b0, 1'b1, 1'b0, 1'b1);
      set_port(1, 54'h900, 2'd0, LD, 1'b1, 1'b0, 1'b0, 1'b0); tick();
      set_port(0, 54'h401, 2'd0, LD, 1'b1, 1'b0, 1'b0, 1'b0);
      set_port(1, 54'h401, 2'd0, ST, 1'b1, 1'b0, 1'b1, 1'b1); tick();
      set_port(0, 54'h600, 2'd0, LD, 1'b1, 1'b0, 1'b0, 1'b1);
      set_port(1, 54'h600, 2'd0, LD, 1'b1, 1'b0, 1'b0, 1'b1); tick();
      set_port(0, 54'h401, 2'd0, LD, 1'b0, 1'b1, 1'b0, 1'b0);
      set_port(1, 54'h900, 2'd0, ST, 1'b0, 1'b1, 1'b0, 1'b1); tick();
      reset = 1'b1;
      chk_valid = 2'b00;
      tick();
      reset = 1'b0;
      check("post_rst_res_valid", 64'(res_valid), 64'd0);
      check("post_rst_res_tag", 64'(res_tag), 64'd0);
      check("post_rst_res_fail", 64'(res_fail), 64'd0);
      fl0 = q0.size(); fl1 = q1.size();
      check("lost_in_flight_p0", 64'(fl0), 64'd1);
      check("lost_in_flight_p1", 64'(fl1), 64'd1);
      q0.delete(); q1.delete();
      tick(); tick();
      check("post_rst_no_result", 64'(res_valid), 64'd0);
      rd_check(4'd1, 8'h00, '0);

      // Table cleared by reset: previously faulting access now passes
      req(0, 54'h400, 2'd0, ST, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
